wb_collector: RTL and testbench
===============================

# wb_collector

Writeback collector sitting directly downstream of the execution-lane `Pipe` stages. Each lane's pipe-output bundle is buffered in a small per-lane FIFO. One op per cycle is arbitrated round-robin onto the single register-file writeback / reservation-station retire port. FIFO occupancy is fed back to each lane as that lane's `stall`.

## Interface
Parameters:
- `NumLanes`, default 2: number of upstream pipe lanes (≥1).
- `FifoDepth`, default 2: entries per lane FIFO (power of two, ≥2).

Ports, with per-lane ports packed `[NumLanes-1:0]`:
- `clk`  in  1: the only clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `iOpValid`  in  NumLanes: lane output op valid.
- `iMask`  in  Mask_t×NumLanes: lane thread mask.
- `iDstRegValid`  in  NumLanes: op writes a destination register.
- `iDstRegVID`  in  VRegIdx_t×NumLanes: destination register index.
- `iDstRegType`  in  NumLanes: destination register type.
- `iRID`  in  RsvID_t×NumLanes: reservation-station ID.
- `stall`  out  NumLanes: freeze request to each lane's pipe.
- `oWbValid`  out  1: writeback/retire beat valid.
- `oWbWrite`  out  1: beat writes the register file (copy of the entry's DstRegValid).
- `oWbMask`  out  Mask_t: mask of the beat.
- `oWbVID`  out  VRegIdx_t: destination index of the beat.
- `oWbType`  out  1: destination type of the beat.
- `oWbRID`  out  RsvID_t: RID to retire.
- `oWbLane`  out  $clog2(NumLanes) (min 1): source lane of the beat.
- `wbReady`  in  1: consumer accepts the beat this cycle.

## Operation
- **Enqueue rule.** Lane i enqueues when `iOpValid[i] && !stall[i]`.
  - While `stall[i]=1` the pipe holds its output. That held op must not be enqueued, so nothing is captured and nothing is duplicated.
- **Stall.** `stall[i] = (count[i] == FifoDepth)`.
  - It is a function of registered state only, with no combinational path from `wbReady` or any input.
- **FIFO entry.** Stores {Mask, DstRegValid, DstRegVID, DstRegType, RID}.
  - Read and write pointers are `$clog2(FifoDepth)` bits wide and wrap naturally.
  - `count` is `$clog2(FifoDepth)+1` bits.
  - A simultaneous push and pop on one lane leaves count unchanged. This is legal at any occupancy, including full, but a push while full cannot happen because `stall` is high.
- **Arbiter, round-robin.**
  - State: `rrPtr` (reset value 0), `lockValid` (reset value 0), `lockLane` (reset value 0).
  - When `lockValid=0`, the grant is the first non-empty lane searched from `rrPtr` upward, wrapping around.
  - When `lockValid=1`, the grant is `lockLane`.
- **Output.** `oWbValid` = the granted lane is non-empty. The `oWb*` fields come from that lane's FIFO head.
- **Handshake.** A transfer happens when `oWbValid && wbReady`. On a transfer:
  - the granted FIFO pops;
  - `rrPtr` ← grant+1, wrapping to 0 at NumLanes;
  - `lockValid` ← 0.
- **Backpressure.** If `oWbValid && !wbReady`, then `lockValid` ← 1 and `lockLane` ← grant.
  - All `oWb*` outputs stay bit-stable until the transfer, even if other lanes become non-empty.
- **Retire-only ops.** Ops with `DstRegValid=0` still produce a beat, with `oWbValid=1` and `oWbWrite=0`.
- **Empty-mask ops.** An all-zero mask is passed through unchanged; no special case.
- **Reset.**
  - Reset has priority over everything and clears all counts, pointers, `rrPtr` and the lock.
  - In-flight FIFO contents are discarded. Payload storage is not cleared.

## Timing
- Minimum latency is 1 cycle: an op enqueued at edge N can appear on `oWbValid` in the cycle after edge N. There is no same-cycle bypass.
- Throughput is 1 beat per cycle aggregate, and a single lane can sustain 1 op per cycle.
- Output values during and after reset:
  - `stall` = 0;
  - `oWbValid` = 0;
  - `oWbLane` = 0;
  - the other `oWb*` fields are don't-care while `oWbValid=0`.
- `stall[i]` rises in the cycle after the edge at which `count[i]` reaches FifoDepth. It falls in the cycle after the edge of the pop that frees an entry.
- Reset asserted mid-backpressure: the cycle after that edge, `oWbValid=0` and `stall=0`. `wbReady` is ignored while `rst=1`.

## Test plan
- **Single op.** With `wbReady=1`, drive lane0 for one cycle: iOpValid=1, mask=0xFFFF_FFFF, VID=5, Type=1, RID=3, DstRegValid=1.
  - The next cycle shows `oWbValid=1`, `oWbWrite=1`, VID=5, RID=3, Lane=0. The cycle after shows `oWbValid=0`.
- **Round-robin.** Lanes 0 and 1 each push one op with RID 1 and RID 2 in the same cycle, `wbReady=1`.
  - Beats are RID1 (lane0) then RID2 (lane1).
  - Repeat the same push: order is lane0 then lane1 again, because `rrPtr` returned to 0.
- **Backpressure with a lower-priority arrival.**
  - Lane1 op RID=4 is pending while `wbReady=0`. Lane0 then pushes RID=6.
  - The output stays RID=4, Lane=1 for 5 cycles.
  - Raise `wbReady`: RID4 transfers first, then RID6.
- **Full and stall.** With `wbReady=0`, lane0 has iOpValid=1 every cycle with RID 1, 2, 3…, held while stalled.
  - `stall[0]=1` after two pushes, and RID3 is not captured while stalled.
  - Release `wbReady`: beats are exactly RID1, RID2, RID3, with no duplicates.
- **Retire-only op.** Push DstRegValid=0 with RID=7.
  - `oWbValid=1`, `oWbWrite=0`, `oWbRID=7`.
- **Mid-operation reset.** With 2 entries per lane and `wbReady=0`, assert `rst` for 1 cycle.
  - Next cycle: `oWbValid=0` and `stall=00`.
  - A new lane1 push then appears 1 cycle later with Lane=1.

Source files
------------

// File: rtl/wb_collector.sv
// Writeback collector: per-lane FIFOs drained one beat per cycle by a
// round-robin arbiter onto the single register-file writeback / retire port.
module wb_collector #(
  parameter int NumLanes  = 2,
  parameter int FifoDepth = 2,
  parameter int MaskWidth = 32,
  parameter int VRegWidth = 6,
  parameter int RidWidth  = 4,
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1,
  localparam int PtrW     = $clog2(FifoDepth),
  localparam int CntW     = $clog2(FifoDepth) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumLanes-1:0]                 iOpValid,
  input  logic [NumLanes-1:0][MaskWidth-1:0]  iMask,
  input  logic [NumLanes-1:0]                 iDstRegValid,
  input  logic [NumLanes-1:0][VRegWidth-1:0]  iDstRegVID,
  input  logic [NumLanes-1:0]                 iDstRegType,
  input  logic [NumLanes-1:0][RidWidth-1:0]   iRID,
  output logic [NumLanes-1:0]                 stall,
  output logic                                oWbValid,
  output logic                                oWbWrite,
  output logic [MaskWidth-1:0]                oWbMask,
  output logic [VRegWidth-1:0]                oWbVID,
  output logic                                oWbType,
  output logic [RidWidth-1:0]                 oWbRID,
  output logic [LaneW-1:0]                    oWbLane,
  input  logic                                wbReady
);

  typedef struct packed {
    logic [MaskWidth-1:0] mask;
    logic                 dst_valid;
    logic [VRegWidth-1:0] vid;
    logic                 dst_type;
    logic [RidWidth-1:0]  rid;
  } entry_t;

  logic [NumLanes-1:0]         empty;
  entry_t [NumLanes-1:0]       lane_head;
  entry_t                      head;
  logic [LaneW-1:0]            rr_ptr;
  logic [LaneW-1:0]            lock_lane;
  logic                        lock_valid;
  logic [LaneW-1:0]            grant;
  logic [LaneW-1:0]            cand;
  logic                        transfer;

  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    entry_t          mem [FifoDepth];
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    logic            push;
    logic            pop;

    // stall comes from registered count only, so a held op is never re-captured
    assign stall[i]     = (count == CntW'(FifoDepth));
    assign empty[i]     = (count == '0);
    assign push         = iOpValid[i] && !stall[i];
    assign pop          = transfer && (grant == LaneW'(i));
    assign lane_head[i] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
        if (push && !pop)      count <= count + CntW'(1);
        else if (pop && !push) count <= count - CntW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= '{mask:      iMask[i],
                         dst_valid: iDstRegValid[i],
                         vid:       iDstRegVID[i],
                         dst_type:  iDstRegType[i],
                         rid:       iRID[i]};
      end
    end
  end

  // Search downward so the lane closest to rr_ptr is the last (winning) match.
  always_comb begin
    grant = rr_ptr;
    cand  = '0;
    if (lock_valid) begin
      grant = lock_lane;
    end else begin
      for (int k = NumLanes - 1; k >= 0; k--) begin
        cand = LaneW'((int'(rr_ptr) + k) % NumLanes);
        if (!empty[cand]) grant = cand;
      end
    end
  end

  assign head     = lane_head[grant];
  assign oWbValid = !empty[grant];
  assign oWbWrite = head.dst_valid;
  assign oWbMask  = head.mask;
  assign oWbVID   = head.vid;
  assign oWbType  = head.dst_type;
  assign oWbRID   = head.rid;
  assign oWbLane  = grant;
  assign transfer = oWbValid && wbReady;

  // A stalled beat locks the grant so the outputs stay stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_lane  <= '0;
    end else if (transfer) begin
      rr_ptr     <= (grant == LaneW'(NumLanes - 1)) ? '0 : grant + LaneW'(1);
      lock_valid <= 1'b0;
    end else if (oWbValid) begin
      lock_valid <= 1'b1;
      lock_lane  <= grant;
    end
  end

endmodule

// File: tb/tb_wb_collector.sv
// Directed bench for wb_collector: per-cycle vector table plus hand-built
// sequences for mid-backpressure reset and retire-only ops.
module tb_wb_collector;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        iOpValid;
  logic [1:0][31:0]  iMask;
  logic [1:0]        iDstRegValid;
  logic [1:0][5:0]   iDstRegVID;
  logic [1:0]        iDstRegType;
  logic [1:0][3:0]   iRID;
  logic [1:0]        stall;
  logic              oWbValid;
  logic              oWbWrite;
  logic [31:0]       oWbMask;
  logic [5:0]        oWbVID;
  logic              oWbType;
  logic [3:0]        oWbRID;
  logic              oWbLane;
  logic              wbReady;

  int checks = 0;
  int errors = 0;

  wb_collector #(
    .NumLanes(2), .FifoDepth(2), .MaskWidth(32), .VRegWidth(6), .RidWidth(4)
  ) dut (
    .clk(clk), .rst(rst),
    .iOpValid(iOpValid), .iMask(iMask), .iDstRegValid(iDstRegValid),
    .iDstRegVID(iDstRegVID), .iDstRegType(iDstRegType), .iRID(iRID),
    .stall(stall),
    .oWbValid(oWbValid), .oWbWrite(oWbWrite), .oWbMask(oWbMask),
    .oWbVID(oWbVID), .oWbType(oWbType), .oWbRID(oWbRID), .oWbLane(oWbLane),
    .wbReady(wbReady)
  );

  always #5 clk = ~clk;

  // Inputs held across one rising edge, then the outputs expected after it.
  typedef struct packed {
    logic        rst;
    logic        ready;
    logic [1:0]  v;
    logic [1:0]  dv;
    logic [1:0]  ty;
    logic [3:0]  rid0;
    logic [5:0]  vid0;
    logic [31:0] m0;
    logic [3:0]  rid1;
    logic [5:0]  vid1;
    logic [31:0] m1;
    logic        ev;
    logic        ew;
    logic [3:0]  erid;
    logic [5:0]  evid;
    logic        ety;
    logic [31:0] emask;
    logic        elane;
    logic [1:0]  estall;
    logic        clane;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    rst          = t.rst;
    wbReady      = t.ready;
    iOpValid     = t.v;
    iDstRegValid = t.dv;
    iDstRegType  = t.ty;
    iRID[0]      = t.rid0;
    iDstRegVID[0] = t.vid0;
    iMask[0]     = t.m0;
    iRID[1]      = t.rid1;
    iDstRegVID[1] = t.vid1;
    iMask[1]     = t.m1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t t, input string tag);
    check({tag, ".valid"}, 32'(oWbValid), 32'(t.ev));
    check({tag, ".stall"}, 32'(stall), 32'(t.estall));
    if (t.ev) begin
      check({tag, ".write"}, 32'(oWbWrite), 32'(t.ew));
      check({tag, ".rid"},   32'(oWbRID),   32'(t.erid));
      check({tag, ".vid"},   32'(oWbVID),   32'(t.evid));
      check({tag, ".type"},  32'(oWbType),  32'(t.ety));
      check({tag, ".mask"},  oWbMask,       t.emask);
    end
    if (t.ev || t.clane) check({tag, ".lane"}, 32'(oWbLane), 32'(t.elane));
  endtask

  function automatic vec_t idle(input logic ready);
    vec_t t;
    t = '0;
    t.ready = ready;
    return t;
  endfunction

  task automatic midResetSequence();
    vec_t t;
    // two entries per lane with the consumer stalled
    t = idle(1'b0);
    t.v = 2'b11; t.dv = 2'b11;
    t.rid0 = 4'd10; t.vid0 = 6'd40; t.m0 = 32'h0000_00A0;
    t.rid1 = 4'd11; t.vid1 = 6'd41; t.m1 = 32'h0000_00B1;
    t.ev = 1'b1; t.ew = 1'b1; t.erid = 4'd11; t.evid = 6'd41; t.emask = 32'h0000_00B1; t.elane = 1'b1;
    applyStimulus(t); checkOutput(t, "rst_fill1");
    t.rid0 = 4'd12; t.rid1 = 4'd13; t.estall = 2'b11;
    applyStimulus(t); checkOutput(t, "rst_fill2");
    // reset with wbReady high and pushes pending: all ignored
    t = idle(1'b1);
    t.rst = 1'b1; t.v = 2'b11; t.dv = 2'b11; t.rid0 = 4'd14; t.rid1 = 4'd15;
    t.clane = 1'b1;
    applyStimulus(t); checkOutput(t, "rst_mid");
    t = idle(1'b0);
    t.v = 2'b10; t.dv = 2'b10; t.rid1 = 4'd9; t.vid1 = 6'd9; t.m1 = 32'h0000_0009;
    t.ev = 1'b1; t.ew = 1'b1; t.erid = 4'd9; t.evid = 6'd9; t.emask = 32'h0000_0009; t.elane = 1'b1;
    applyStimulus(t); checkOutput(t, "rst_after");
  endtask

  task automatic retireOnlySequence();
    vec_t t;
    t = idle(1'b1);
    applyStimulus(t); checkOutput(t, "ret_drain");
    t = idle(1'b1);
    t.v = 2'b01; t.dv = 2'b00; t.rid0 = 4'd7; t.vid0 = 6'd7; t.m0 = 32'h0000_0007;
    t.ev = 1'b1; t.ew = 1'b0; t.erid = 4'd7; t.evid = 6'd7; t.emask = 32'h0000_0007; t.elane = 1'b0;
    applyStimulus(t); checkOutput(t, "ret_beat");
    t = idle(1'b1);
    applyStimulus(t); checkOutput(t, "ret_done");
  endtask

  initial begin
    rst = 1'b1; wbReady = 1'b0; iOpValid = '0; iMask = '0; iDstRegValid = '0;
    iDstRegVID = '0; iDstRegType = '0; iRID = '0;

    //            rst   rdy   v      dv     ty     rid0   vid0   m0             rid1   vid1   m1            ev    ew    erid   evid   ety   emask          elane estall clane
    tbl[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 4'd3, 6'd5,  32'hFFFF_FFFF, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd3, 6'd5,  1'b1, 32'hFFFF_FFFF, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b10, 4'd1, 6'd10, 32'h0000_00F1, 4'd2, 6'd20, 32'h0000_0F02, 1'b1, 1'b1, 4'd1, 6'd10, 1'b0, 32'h0000_00F1, 1'b0, 2'b00, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd2, 6'd20, 1'b1, 32'h0000_0F02, 1'b1, 2'b00, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'b11, 2'b11, 2'b10, 4'd1, 6'd10, 32'h0000_00F1, 4'd2, 6'd20, 32'h0000_0F02, 1'b1, 1'b1, 4'd1, 6'd10, 1'b0, 32'h0000_00F1, 1'b0, 2'b00, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd2, 6'd20, 1'b1, 32'h0000_0F02, 1'b1, 2'b00, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 4'd0, 6'd0,  32'h0,         4'd4, 6'd33, 32'h0,        1'b1, 1'b1, 4'd4, 6'd33, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 4'd6, 6'd12, 32'h1234_5678, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd4, 6'd33, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd4, 6'd33, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd4, 6'd33, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd4, 6'd33, 1'b0, 32'h0,         1'b1, 2'b00, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd6, 6'd12, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 4'd1, 6'd1,  32'h0000_0011, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd1, 6'd1,  1'b0, 32'h0000_0011, 1'b0, 2'b00, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 4'd2, 6'd2,  32'h0000_0022, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd1, 6'd1,  1'b0, 32'h0000_0011, 1'b0, 2'b01, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 4'd3, 6'd3,  32'h0000_0033, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd1, 6'd1,  1'b0, 32'h0000_0011, 1'b0, 2'b01, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 4'd3, 6'd3,  32'h0000_0033, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd1, 6'd1,  1'b0, 32'h0000_0011, 1'b0, 2'b01, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 4'd3, 6'd3,  32'h0000_0033, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd2, 6'd2,  1'b0, 32'h0000_0022, 1'b0, 2'b00, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 4'd3, 6'd3,  32'h0000_0033, 4'd0, 6'd0,  32'h0,        1'b1, 1'b1, 4'd3, 6'd3,  1'b0, 32'h0000_0033, 1'b0, 2'b00, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 6'd0,  32'h0,         4'd0, 6'd0,  32'h0,        1'b0, 1'b0, 4'd0, 6'd0,  1'b0, 32'h0,         1'b0, 2'b00, 1'b0};

    #1;
    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], $sformatf("v%0d", i));
    end

    midResetSequence();
    retireOnlySequence();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
